sprite_attr_mem: RTL and testbench
==================================

SPRITE_ATTR_MEM -- requirements
Module: sprite_attr_mem

Interface
REQ-001 Parameters: NUM_SPRITES, 256, number of sprite records; FLD_W, 8, width of each attribute field.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 sprite_fcn  input  4  attribute select from the EX stage.
REQ-005 sprite_addr  input  8  sprite index from the EX stage.
REQ-006 sprite_write_data  input  8  write data from the EX stage.
REQ-007 sprite_re  input  1  CPU read request.
REQ-008 sprite_we  input  1  CPU write or command request.
REQ-009 sprite_data  output  32  CPU read data, zero-extended field.
REQ-010 sprite_valid  output  1  sprite_data valid strobe.
REQ-011 sprite_busy  output  1  motion sweep in progress; CPU requests ignored.
REQ-012 sweep_done  output  1  one-cycle pulse at sweep completion.
REQ-013 disp_addr  input  8  display-side sprite index.
REQ-014 disp_re  input  1  display read request.
REQ-015 disp_attr  output  32  {FLAGS, IMG, Y, X}, bits 31:24 down to 7:0.
REQ-016 disp_valid  output  1  disp_attr valid strobe.

Function
REQ-017 Per sprite, six 8-bit fields by sprite_fcn: 0 X, 1 Y, 2 IMG, 3 FLAGS (bit0 enable, bit1 hflip, bit2 vflip, bits 7:3 stored as written), 4 VX (signed), 5 VY (signed).
REQ-018 fcn 6-14: writes discarded; reads return 0 with sprite_valid asserted.
REQ-019 Write: sprite_we with fcn 0-5 while idle updates the field at the clock edge.
REQ-020 Read: sprite_re while idle produces sprite_data and sprite_valid exactly one cycle later; sprite_valid is low otherwise.
REQ-021 sprite_data holds its last value when sprite_valid is low.
REQ-022 sprite_re and sprite_we together: the write is performed, the read is dropped, and sprite_valid stays low the next cycle.
REQ-023 A read one cycle after a write to the same field returns the new value.
REQ-024 Command: sprite_we with fcn 15 while idle starts a motion sweep; write data is ignored.
REQ-025 State machine: IDLE -> SWEEP on command; SWEEP -> IDLE after index 255 is processed; no other transitions except reset.
REQ-026 sprite_busy is high from the cycle after the command through the final sweep cycle: exactly 256 cycles.
REQ-027 SWEEP cycle k (k = 0..255) processes sprite k: if FLAGS[0]=1, X <= X + VX and Y <= Y + VY (VX and VY sign-extended, result mod 256, wrap-around without saturation); otherwise the record is unchanged.
REQ-028 sweep_done pulses high for one cycle, the first cycle after sprite_busy falls.
REQ-029 CPU reads and writes presented while sprite_busy is high are ignored: no state change and no sprite_valid.
REQ-030 A fcn-15 command while busy is ignored; it neither restarts nor extends the sweep.
REQ-031 Display port is always served, including during a sweep: disp_valid and disp_attr follow disp_re by one cycle.
REQ-032 During a sweep, disp_attr returns the value stored at the moment of the read; a record being updated in the same cycle returns its pre-update value.
REQ-033 disp_attr holds its value when disp_valid is low.

Reset
REQ-034 rst clears all attribute fields of every sprite to 0.
REQ-035 rst forces the state to IDLE and clears the sweep index.
REQ-036 rst drives sprite_data, disp_attr, sprite_valid, disp_valid, sprite_busy and sweep_done to 0.
REQ-037 rst asserted mid-sweep aborts the sweep with no sweep_done pulse.
REQ-038 rst has priority over any concurrent request.
REQ-039 Requests are accepted starting in the first cycle after rst deasserts.

Verification
REQ-040 Write/read: write sprite 7 fcn 0 = 0x5A; read sprite 7 fcn 0 next cycle -> sprite_valid one cycle later, sprite_data = 0x0000005A.
REQ-041 Simultaneous and reserved: re+we, sprite 3 fcn 1 = 0x11 -> no valid; then read -> 0x11. Read fcn 9 -> 0x00000000 with valid.
REQ-042 Sweep wrap: sprite 0 has X=0xF0, VX=0x20, Y=0x05, VY=0xFA (-6), FLAGS=1; sprite 1 has the same X/VX with FLAGS=0. Issue fcn 15 -> busy for 256 cycles, then sweep_done pulse. Sprite 0 X=0x10, Y=0xFF; sprite 1 X=0xF0.
REQ-043 Busy lockout: during a sweep, write sprite 9 fcn 2 = 0x77 and issue a second fcn 15 -> IMG stays 0, busy drops exactly 256 cycles after the first command.
REQ-044 Display port: disp_re on sprite 0 during a sweep -> disp_valid one cycle later, disp_attr = {FLAGS, IMG, Y, X} current values.
REQ-045 Reset mid-sweep: assert rst at sweep cycle 100 -> next cycle busy=0, no sweep_done, and every read returns 0.

Source files
------------

// File: rtl/sprite_attr_mem.sv
// Sprite attribute store: six byte fields per sprite, a CPU port, a display port,
// and a 256-cycle motion sweep that adds signed velocity to the position of enabled sprites.
module sprite_attr_mem #(
    parameter int NUM_SPRITES = 256,
    parameter int FLD_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         sprite_fcn,
    input  logic [7:0]         sprite_addr,
    input  logic [FLD_W-1:0]   sprite_write_data,
    input  logic               sprite_re,
    input  logic               sprite_we,
    output logic [31:0]        sprite_data,
    output logic               sprite_valid,
    output logic               sprite_busy,
    output logic               sweep_done,
    input  logic [7:0]         disp_addr,
    input  logic               disp_re,
    output logic [4*FLD_W-1:0] disp_attr,
    output logic               disp_valid
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    typedef enum logic [3:0] {
        FCN_X     = 4'd0,
        FCN_Y     = 4'd1,
        FCN_IMG   = 4'd2,
        FCN_FLAGS = 4'd3,
        FCN_VX    = 4'd4,
        FCN_VY    = 4'd5,
        FCN_SWEEP = 4'd15
    } fcn_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_SPRITES - 1);

    logic [FLD_W-1:0] r_x     [NUM_SPRITES];
    logic [FLD_W-1:0] r_y     [NUM_SPRITES];
    logic [FLD_W-1:0] r_img   [NUM_SPRITES];
    logic [FLD_W-1:0] r_flags [NUM_SPRITES];
    logic [FLD_W-1:0] r_vx    [NUM_SPRITES];
    logic [FLD_W-1:0] r_vy    [NUM_SPRITES];

    state_t           r_state;
    logic [7:0]       r_sweep_idx;

    logic             w_idle;
    logic             w_cpu_wr;
    logic             w_cpu_rd;
    logic             w_cmd;
    logic [FLD_W-1:0] w_rd_field;
    logic [31:0]      w_rd_data;
    logic [4*FLD_W-1:0] w_disp_data;

    // A simultaneous read and write performs only the write; nothing is accepted mid-sweep.
    assign w_idle   = (r_state == S_IDLE);
    assign w_cpu_wr = w_idle && sprite_we && (sprite_fcn <= FCN_VY);
    assign w_cmd    = w_idle && sprite_we && (sprite_fcn == FCN_SWEEP);
    assign w_cpu_rd = w_idle && sprite_re && !sprite_we;

    always_comb begin
        // NOTE: default assignment first so no path leaves w_rd_field unassigned (no latch).
        w_rd_field = '0;
        case (sprite_fcn)
            FCN_X:     w_rd_field = r_x[sprite_addr];
            FCN_Y:     w_rd_field = r_y[sprite_addr];
            FCN_IMG:   w_rd_field = r_img[sprite_addr];
            FCN_FLAGS: w_rd_field = r_flags[sprite_addr];
            FCN_VX:    w_rd_field = r_vx[sprite_addr];
            FCN_VY:    w_rd_field = r_vy[sprite_addr];
            default:   w_rd_field = '0;
        endcase
    end

    assign w_rd_data   = 32'(w_rd_field);
    assign w_disp_data = {r_flags[disp_addr], r_img[disp_addr], r_y[disp_addr], r_x[disp_addr]};

    // Attribute storage: CPU writes while idle, position update while sweeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage is cleared by reset, so it must be flops rather than a RAM macro.
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_x[i]     <= '0;
                r_y[i]     <= '0;
                r_img[i]   <= '0;
                r_flags[i] <= '0;
                r_vx[i]    <= '0;
                r_vy[i]    <= '0;
            end
        end else if (w_cpu_wr) begin
            case (sprite_fcn)
                FCN_X:     r_x[sprite_addr]     <= sprite_write_data;
                FCN_Y:     r_y[sprite_addr]     <= sprite_write_data;
                FCN_IMG:   r_img[sprite_addr]   <= sprite_write_data;
                FCN_FLAGS: r_flags[sprite_addr] <= sprite_write_data;
                FCN_VX:    r_vx[sprite_addr]    <= sprite_write_data;
                FCN_VY:    r_vy[sprite_addr]    <= sprite_write_data;
                default:   ;
            endcase
        end else if (r_state == S_SWEEP && r_flags[r_sweep_idx][0]) begin
            // Two's-complement add at field width gives the signed, wrapping update.
            r_x[r_sweep_idx] <= r_x[r_sweep_idx] + r_vx[r_sweep_idx];
            r_y[r_sweep_idx] <= r_y[r_sweep_idx] + r_vy[r_sweep_idx];
        end
    end

    // Sweep control and registered port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_state      <= S_IDLE;
            r_sweep_idx  <= '0;
            sprite_data  <= '0;
            sprite_valid <= 1'b0;
            sprite_busy  <= 1'b0;
            sweep_done   <= 1'b0;
            disp_attr    <= '0;
            disp_valid   <= 1'b0;
        end else begin
            sprite_valid <= w_cpu_rd;
            if (w_cpu_rd) begin
                sprite_data <= w_rd_data;
            end

            disp_valid <= disp_re;
            if (disp_re) begin
                disp_attr <= w_disp_data;
            end

            sweep_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cmd) begin
                        r_state     <= S_SWEEP;
                        r_sweep_idx <= '0;
                        sprite_busy <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (r_sweep_idx == LAST_IDX) begin
                        r_state     <= S_IDLE;
                        r_sweep_idx <= '0;
                        sprite_busy <= 1'b0;
                        sweep_done  <= 1'b1;
                    end else begin
                        r_sweep_idx <= r_sweep_idx + 8'd1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    sprite_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_attr_mem.sv
// Scoreboard bench for sprite_attr_mem: directed stimulus pushes expected read data,
// a negedge monitor pops and compares whenever a valid strobe appears.
module tb_sprite_attr_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sprite_fcn;
    logic [7:0]  sprite_addr;
    logic [7:0]  sprite_write_data;
    logic        sprite_re;
    logic        sprite_we;
    logic [31:0] sprite_data;
    logic        sprite_valid;
    logic        sprite_busy;
    logic        sweep_done;
    logic [7:0]  disp_addr;
    logic        disp_re;
    logic [31:0] disp_attr;
    logic        disp_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_sprite_q[$];
    logic [31:0] exp_disp_q[$];

    always #5 clk = ~clk;

    sprite_attr_mem #(.NUM_SPRITES(256), .FLD_W(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .sprite_fcn        (sprite_fcn),
        .sprite_addr       (sprite_addr),
        .sprite_write_data (sprite_write_data),
        .sprite_re         (sprite_re),
        .sprite_we         (sprite_we),
        .sprite_data       (sprite_data),
        .sprite_valid      (sprite_valid),
        .sprite_busy       (sprite_busy),
        .sweep_done        (sweep_done),
        .disp_addr         (disp_addr),
        .disp_re           (disp_re),
        .disp_attr         (disp_attr),
        .disp_valid        (disp_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every valid strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (sprite_valid === 1'b1) begin
            if (exp_sprite_q.size() == 0) check("spurious sprite_valid", {31'd0, sprite_valid}, 32'd0);
            else check("sprite_data", sprite_data, exp_sprite_q.pop_front());
        end
        if (disp_valid === 1'b1) begin
            if (exp_disp_q.size() == 0) check("spurious disp_valid", {31'd0, disp_valid}, 32'd0);
            else check("disp_attr", disp_attr, exp_disp_q.pop_front());
        end
    end

    task automatic idle_inputs();
        sprite_re         = 1'b0;
        sprite_we         = 1'b0;
        sprite_fcn        = 4'd0;
        sprite_addr       = 8'd0;
        sprite_write_data = 8'd0;
        disp_re           = 1'b0;
        disp_addr         = 8'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [3:0] f, input logic [7:0] d);
        sprite_we = 1'b1; sprite_addr = a; sprite_fcn = f; sprite_write_data = d;
        tick();
        idle_inputs();
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [3:0] f, input logic [31:0] exp);
        sprite_re = 1'b1; sprite_addr = a; sprite_fcn = f;
        exp_sprite_q.push_back(exp);
        tick();
        idle_inputs();
    endtask

    task automatic disp_read(input logic [7:0] a, input logic [31:0] exp);
        disp_re = 1'b1; disp_addr = a;
        exp_disp_q.push_back(exp);
        tick();
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int bad_done;

        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        check("reset busy",        {31'd0, sprite_busy},  32'd0);
        check("reset sprite_valid",{31'd0, sprite_valid}, 32'd0);
        check("reset disp_valid",  {31'd0, disp_valid},   32'd0);
        check("reset sweep_done",  {31'd0, sweep_done},   32'd0);
        check("reset sprite_data", sprite_data,           32'd0);
        check("reset disp_attr",   disp_attr,             32'd0);
        rst = 1'b0;

        // Write in the very first cycle after reset, read back the next cycle.
        cpu_write(8'd7, 4'd0, 8'h5A);
        cpu_read(8'd7, 4'd0, 32'h0000_005A);

        // Simultaneous re+we: write happens, no read strobe.
        sprite_re = 1'b1; sprite_we = 1'b1; sprite_addr = 8'd3; sprite_fcn = 4'd1;
        sprite_write_data = 8'h11;
        tick();
        idle_inputs();
        cpu_read(8'd3, 4'd1, 32'h0000_0011);

        // Reserved function codes.
        cpu_read(8'd3, 4'd9, 32'h0);
        cpu_write(8'd3, 4'd9, 8'hAA);
        cpu_read(8'd3, 4'd9, 32'h0);
        cpu_write(8'd3, 4'd14, 8'hBB);
        cpu_read(8'd3, 4'd14, 32'h0);

        // FLAGS upper bits stored verbatim.
        cpu_write(8'd5, 4'd3, 8'hF9);
        cpu_read(8'd5, 4'd3, 32'h0000_00F9);
        disp_read(8'd7, 32'h0000_005A);

        // Sweep setup: sprite 0 enabled, sprite 1 disabled.
        cpu_write(8'd0, 4'd0, 8'hF0);
        cpu_write(8'd0, 4'd4, 8'h20);
        cpu_write(8'd0, 4'd1, 8'h05);
        cpu_write(8'd0, 4'd5, 8'hFA);
        cpu_write(8'd0, 4'd3, 8'h01);
        cpu_write(8'd1, 4'd0, 8'hF0);
        cpu_write(8'd1, 4'd4, 8'h20);
        disp_read(8'd0, 32'h0100_05F0);

        cpu_write(8'd0, 4'd15, 8'h33);
        check("busy after command", {31'd0, sprite_busy}, 32'd1);
        cnt = 0;
        bad_done = 0;
        while (sprite_busy === 1'b1 && cnt < 300) begin
            idle_inputs();
            case (cnt)
                0: begin disp_re = 1'b1; disp_addr = 8'd0; exp_disp_q.push_back(32'h0100_05F0); end
                1: begin disp_re = 1'b1; disp_addr = 8'd0; exp_disp_q.push_back(32'h0100_FF10); end
                2: begin disp_re = 1'b1; disp_addr = 8'd1; exp_disp_q.push_back(32'h0000_00F0); end
                5: begin sprite_we = 1'b1; sprite_addr = 8'd9; sprite_fcn = 4'd2; sprite_write_data = 8'h77; end
                6: begin sprite_we = 1'b1; sprite_fcn = 4'd15; end
                7: begin sprite_re = 1'b1; sprite_addr = 8'd7; sprite_fcn = 4'd0; end
                default: ;
            endcase
            if (sweep_done !== 1'b0) bad_done++;
            tick();
            cnt++;
        end
        idle_inputs();
        check("busy cycles", cnt, 32'd256);
        check("sweep_done low while busy", bad_done, 32'd0);
        check("sweep_done pulse", {31'd0, sweep_done}, 32'd1);
        tick();
        check("sweep_done one cycle", {31'd0, sweep_done}, 32'd0);

        cpu_read(8'd0, 4'd0, 32'h0000_0010);
        cpu_read(8'd0, 4'd1, 32'h0000_00FF);
        cpu_read(8'd1, 4'd0, 32'h0000_00F0);
        cpu_read(8'd0, 4'd4, 32'h0000_0020);
        cpu_read(8'd9, 4'd2, 32'h0000_0000);
        cpu_read(8'd7, 4'd0, 32'h0000_005A);
        disp_read(8'd0, 32'h0100_FF10);

        // Reset at sweep cycle 100, with a concurrent write that must lose.
        cpu_write(8'd0, 4'd15, 8'h00);
        cnt = 0;
        while (sprite_busy === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        check("reached sweep cycle 100", cnt, 32'd100);
        rst = 1'b1;
        sprite_we = 1'b1; sprite_addr = 8'd2; sprite_fcn = 4'd0; sprite_write_data = 8'h55;
        tick();
        rst = 1'b0;
        idle_inputs();
        check("busy after mid-sweep reset", {31'd0, sprite_busy}, 32'd0);
        check("no sweep_done after reset", {31'd0, sweep_done}, 32'd0);
        tick();
        check("no late sweep_done", {31'd0, sweep_done}, 32'd0);
        cpu_read(8'd0, 4'd0, 32'h0);
        cpu_read(8'd0, 4'd3, 32'h0);
        cpu_read(8'd7, 4'd0, 32'h0);
        cpu_read(8'd5, 4'd3, 32'h0);
        cpu_read(8'd2, 4'd0, 32'h0);
        disp_read(8'd0, 32'h0);

        repeat (3) tick();
        check("sprite expectations drained", exp_sprite_q.size(), 32'd0);
        check("disp expectations drained", exp_disp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
